// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the MIPS execute stage.
// Radix-2 shift-add multiply and restoring divide, WIDTH steps each, followed
// by one sign-fix cycle that commits hi/lo and pulses done.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;      // product accumulator; low half doubles as quotient
  logic [WIDTH:0]     rem;      // partial remainder, one extra bit for the trial borrow
  logic [WIDTH-1:0]   opnd;     // |a| for multiply, |b| for divide
  logic [WIDTH-1:0]   a_orig;   // raw dividend, returned in hi on divide by zero
  logic               is_div;
  logic               neg_q;    // product / quotient must be negated
  logic               neg_r;    // remainder must be negated (negative dividend)
  logic               dz;

  logic               accept;
  logic               commit;
  logic               last_step;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift, div_trial, div_rem;
  logic               div_ok;
  logic [WIDTH-1:0]   div_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign busy      = (state == MUL) || (state == DIV) || (state == FIX);
  assign done      = (state == DONE);
  assign last_step = (count == CW'(1));

  // Operand magnitudes for signed ops; the most-negative value maps to itself,
  // which is the correct unsigned magnitude.
  assign a_abs = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_abs = (op[0] && b[WIDTH-1]) ? -b : b;

  // Multiply step: add multiplicand when the multiplier LSB is set, then shift right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_acc = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: shift in the next dividend bit and trial-subtract the divisor.
  // rem[WIDTH] is zero after every restore; including it keeps the compare exact.
  assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};
  assign div_ok    = rem[WIDTH] | ~div_trial[WIDTH];
  assign div_rem   = div_ok ? div_trial : div_shift;
  assign div_q     = {acc[WIDTH-2:0], div_ok};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic plus the accept/commit strobes for the datapath.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = op[1] ? DIV : MUL;
        end else begin
          state_next = IDLE;
        end
      end
      MUL, DIV: begin
        if (last_step) state_next = FIX;
      end
      FIX: begin
        commit     = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    // Pipeline flush wins over everything, including a new start.
    if (flush) begin
      state_next = IDLE;
      accept     = 1'b0;
      commit     = 1'b0;
    end
  end

  // Sign correction and divide-by-zero override of the raw iteration result.
  // Signed overflow (most-negative / -1) falls out naturally: the quotient
  // magnitude equals the dividend and negating it yields the same bits.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (!is_div) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (dz) begin
      fix_hi = a_orig;
      fix_lo = '1;
    end else begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end
  end

  // Datapath: operand capture on accept, one iteration per cycle, commit in FIX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      acc         <= '0;
      rem         <= '0;
      opnd        <= '0;
      a_orig      <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        count  <= CW'(WIDTH);
        a_orig <= a;
        is_div <= op[1];
        neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r  <= op[0] & op[1] & a[WIDTH-1];
        dz     <= op[1] & (b == '0);
        rem    <= '0;
        if (op[1]) begin
          opnd <= b_abs;
          acc  <= {{WIDTH{1'b0}}, a_abs};
        end else begin
          opnd <= a_abs;
          acc  <= {{WIDTH{1'b0}}, b_abs};
        end
      end else if (!flush && state == MUL) begin
        acc   <= mul_acc;
        count <= count - 1'b1;
      end else if (!flush && state == DIV) begin
        acc[WIDTH-1:0] <= div_q;
        rem            <= div_rem;
        count          <= count - 1'b1;
      end
      if (commit) begin
        hi          <= fix_hi;
        lo          <= fix_lo;
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=16).
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        flush;
  logic        busy, done, div_by_zero;
  logic [15:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one op at the coming edge and follow it until done or a cycle budget
  // expires. Optionally pulses start or flush at a given cycle count after E0.
  // Returns at #1 after the edge where done was first seen.
  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input int pulse_at, input int flush_at,
                        output int lat, output int busy_cnt, output logic seen);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b10; a = 16'hDEAD; b = 16'h0003;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 30) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        start = (lat == pulse_at);
        flush = (lat == flush_at);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    #1;
    total++;
    if ({busy, done, hi, lo, div_by_zero} !== 35'd0) begin
      bad++; $display("FAIL reset_initial got busy=%b done=%b hi=%h lo=%h dz=%b exp all 0",
                      busy, done, hi, lo, div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, hi, lo, div_by_zero} !== 35'd0) begin
      bad++; $display("FAIL reset_held got busy=%b done=%b hi=%h lo=%h dz=%b exp all 0",
                      busy, done, hi, lo, div_by_zero);
    end
    rst = 1'b1;
  endtask

  task automatic test_multu;
    int lat, bc; logic seen;
    run_op(2'b00, 16'hFFFF, 16'hFFFF, -1, -1, lat, bc, seen);
    total++;
    if (!seen || lat != 17) begin
      bad++; $display("FAIL multu_latency got seen=%b lat=%0d exp lat=17", seen, lat);
    end
    total++;
    if (bc != 17) begin
      bad++; $display("FAIL multu_busy_cycles got %0d exp 17", bc);
    end
    total++;
    if ({hi, lo, div_by_zero, busy} !== {16'hFFFE, 16'h0001, 1'b0, 1'b0}) begin
      bad++; $display("FAIL multu_result got hi=%h lo=%h dz=%b busy=%b exp hi=fffe lo=0001 dz=0 busy=0",
                      hi, lo, div_by_zero, busy);
    end
    @(posedge clk); #1;
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL multu_done_pulse got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_signed_mul;
    int lat, bc; logic seen;
    run_op(2'b01, 16'hFFFE, 16'h0003, -1, -1, lat, bc, seen);
    total++;
    if (!seen || lat != 17 || {hi, lo} !== {16'hFFFF, 16'hFFFA}) begin
      bad++; $display("FAIL mult_neg got seen=%b lat=%0d hi=%h lo=%h exp lat=17 hi=ffff lo=fffa",
                      seen, lat, hi, lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed_div;
    int lat, bc; logic seen;
    run_op(2'b11, 16'hFFF9, 16'h0002, -1, -1, lat, bc, seen);
    total++;
    if (!seen || lat != 17 || {hi, lo, div_by_zero} !== {16'hFFFF, 16'hFFFD, 1'b0}) begin
      bad++; $display("FAIL div_neg_dividend got seen=%b lat=%0d hi=%h lo=%h dz=%b exp hi=ffff lo=fffd dz=0",
                      seen, lat, hi, lo, div_by_zero);
    end
    @(posedge clk); #1;
    run_op(2'b11, 16'h8000, 16'hFFFF, -1, -1, lat, bc, seen);
    total++;
    if (!seen || {hi, lo, div_by_zero} !== {16'h0000, 16'h8000, 1'b0}) begin
      bad++; $display("FAIL div_overflow got seen=%b hi=%h lo=%h dz=%b exp hi=0000 lo=8000 dz=0",
                      seen, hi, lo, div_by_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat, bc; logic seen;
    run_op(2'b10, 16'h1234, 16'h0000, -1, -1, lat, bc, seen);
    total++;
    if (!seen || lat != 17 || {hi, lo, div_by_zero} !== {16'h1234, 16'hFFFF, 1'b1}) begin
      bad++; $display("FAIL divu_zero got seen=%b lat=%0d hi=%h lo=%h dz=%b exp lat=17 hi=1234 lo=ffff dz=1",
                      seen, lat, hi, lo, div_by_zero);
    end
    @(posedge clk); #1;
    run_op(2'b11, 16'hFFF9, 16'h0000, -1, -1, lat, bc, seen);
    total++;
    if (!seen || {hi, lo, div_by_zero} !== {16'hFFF9, 16'hFFFF, 1'b1}) begin
      bad++; $display("FAIL div_signed_zero got seen=%b hi=%h lo=%h dz=%b exp hi=fff9 lo=ffff dz=1",
                      seen, hi, lo, div_by_zero);
    end
    @(posedge clk); #1;
    run_op(2'b10, 16'd100, 16'd7, -1, -1, lat, bc, seen);
    total++;
    if (!seen || {hi, lo, div_by_zero} !== {16'h0002, 16'h000E, 1'b0}) begin
      bad++; $display("FAIL divu_100_7 got seen=%b hi=%h lo=%h dz=%b exp hi=0002 lo=000e dz=0",
                      seen, hi, lo, div_by_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start_and_flush;
    int lat, bc; logic seen;
    // A start pulse mid-operation must be ignored.
    run_op(2'b00, 16'h0003, 16'h0005, 5, -1, lat, bc, seen);
    total++;
    if (!seen || lat != 17 || {hi, lo} !== {16'h0000, 16'h000F}) begin
      bad++; $display("FAIL ignored_start got seen=%b lat=%0d hi=%h lo=%h exp lat=17 hi=0000 lo=000f",
                      seen, lat, hi, lo);
    end
    @(posedge clk); #1;
    // Flush at cycle 8: busy drops next cycle, no done, result registers hold.
    run_op(2'b01, 16'h0100, 16'h0100, -1, 8, lat, bc, seen);
    total++;
    if (seen || bc != 9) begin
      bad++; $display("FAIL flush_abort got done_seen=%b busy_cycles=%0d exp done_seen=0 busy_cycles=9",
                      seen, bc);
    end
    total++;
    if ({hi, lo, div_by_zero, busy} !== {16'h0000, 16'h000F, 1'b0, 1'b0}) begin
      bad++; $display("FAIL flush_hold got hi=%h lo=%h dz=%b busy=%b exp hi=0000 lo=000f dz=0 busy=0",
                      hi, lo, div_by_zero, busy);
    end
    run_op(2'b00, 16'h0100, 16'h0100, -1, -1, lat, bc, seen);
    total++;
    if (!seen || lat != 17 || {hi, lo} !== {16'h0001, 16'h0000}) begin
      bad++; $display("FAIL after_flush got seen=%b lat=%0d hi=%h lo=%h exp lat=17 hi=0001 lo=0000",
                      seen, lat, hi, lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_midop_reset;
    start = 1'b1; op = 2'b11; a = 16'h7000; b = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if ({busy, done, hi, lo, div_by_zero} !== 35'd0) begin
      bad++; $display("FAIL midop_reset got busy=%b done=%b hi=%h lo=%h dz=%b exp all 0",
                      busy, done, hi, lo, div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_back_to_back;
    int lat, bc; logic seen;
    run_op(2'b00, 16'h1234, 16'h0010, -1, -1, lat, bc, seen);
    total++;
    if (!seen || lat != 17 || {hi, lo} !== {16'h0001, 16'h2340}) begin
      bad++; $display("FAIL b2b_first got seen=%b lat=%0d hi=%h lo=%h exp lat=17 hi=0001 lo=2340",
                      seen, lat, hi, lo);
    end
    // Still in the done cycle: start goes high here and is taken at the next edge.
    run_op(2'b11, 16'hFC18, 16'h0030, -1, -1, lat, bc, seen);
    total++;
    if (bc != 17) begin
      bad++; $display("FAIL b2b_busy_no_gap got busy_cycles=%0d exp 17", bc);
    end
    total++;
    if (!seen || lat != 17 || {hi, lo, div_by_zero} !== {16'hFFD8, 16'hFFEC, 1'b0}) begin
      bad++; $display("FAIL b2b_second got seen=%b lat=%0d hi=%h lo=%h dz=%b exp hi=ffd8 lo=ffec dz=0",
                      seen, lat, hi, lo, div_by_zero);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed_mul();
    test_signed_div();
    test_div_zero();
    test_ignored_start_and_flush();
    test_midop_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
